// File: rtl/mc_controller_ext_pkg.sv
// Shared declarations for the extended multicycle MIPS controller.
//   - opcode_t / funct_t : instruction field types (instr[31:26] / instr[5:0])
//   - OP_* / F_*         : opcode and R-type funct encodings
//   - statetype_t        : 4-bit controller state encoding (FETCH = 0)
//   - aluop_t            : abstract ALU operation handed to the ALU decoder
//   - ALUC_*             : concrete alucontrol encodings driven to the datapath
package mips_decls_p;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t OP_R    = 6'b000000;
  localparam opcode_t OP_LW   = 6'b100011;
  localparam opcode_t OP_SW   = 6'b101011;
  localparam opcode_t OP_BEQ  = 6'b000100;
  localparam opcode_t OP_BNE  = 6'b000101;
  localparam opcode_t OP_ADDI = 6'b001000;
  localparam opcode_t OP_SLTI = 6'b001010;
  localparam opcode_t OP_ANDI = 6'b001100;
  localparam opcode_t OP_ORI  = 6'b001101;
  localparam opcode_t OP_J    = 6'b000010;

  localparam funct_t F_ADD = 6'b100000;
  localparam funct_t F_SUB = 6'b100010;
  localparam funct_t F_AND = 6'b100100;
  localparam funct_t F_OR  = 6'b100101;
  localparam funct_t F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BREX    = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    TRAP    = 4'd12
  } statetype_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5
  } aluop_t;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Logical immediates (andi/ori) take a zero-extended immediate.
  function automatic logic is_zext_op(input opcode_t op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_controller_ext_aludec.sv
// ALU decoder: maps the controller's abstract ALU operation (and, for
// R-type instructions, the funct field) onto the datapath alucontrol code.
//   aluop      in  3  abstract operation (aluop_t)
//   funct      in  6  instr[5:0], only consulted for ALU_FUNCT
//   alucontrol out 3  add=010 sub=110 and=000 or=001 slt=111
module aludec_ext
  import mips_decls_p::*;
(
  input  aluop_t      aluop,
  input  funct_t      funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    unique case (aluop)
      ALU_ADD: alucontrol = ALUC_ADD;
      ALU_SUB: alucontrol = ALUC_SUB;
      ALU_AND: alucontrol = ALUC_AND;
      ALU_OR:  alucontrol = ALUC_OR;
      ALU_SLT: alucontrol = ALUC_SLT;
      ALU_FUNCT: begin
        // Unsupported funct codes fall back to add rather than trapping.
        case (funct)
          F_ADD:   alucontrol = ALUC_ADD;
          F_SUB:   alucontrol = ALUC_SUB;
          F_AND:   alucontrol = ALUC_AND;
          F_OR:    alucontrol = ALUC_OR;
          F_SLT:   alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller_ext.sv
// Extended multicycle MIPS control unit.
// Drives the multicycle datapath for lw/sw/R-type/beq/bne/addi/slti/andi/ori/j,
// stalls FETCH/MEMRD/MEMWR on mem_ready, traps illegal opcodes to the
// exception vector and counts retired instructions.
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct        instruction fields from the IR
//   zero                 ALU zero flag (branch resolution)
//   mem_ready            memory access completes this cycle
//   pcen, memwrite, irwrite, regwrite   strobes (forced low while in reset)
//   alusrca, iord, memtoreg, regdst, immsrc, alusrcb, pcsrc, alucontrol
//                        datapath mux selects / ALU op
//   illegal              sticky flag, set once a trap has been taken
//   instret              retired-instruction count (wraps)
//   state_o              current FSM state for debug
module mc_controller_ext
  import mips_decls_p::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int EXT_ISA  = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             immsrc,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  localparam bit WAIT_EN = (MEM_WAIT != 0);
  localparam bit EXT_EN  = (EXT_ISA != 0);

  statetype_t state, next_state;
  aluop_t     aluop;
  logic       rdy;
  logic       pcwrite, branch, branchne;
  logic       memwrite_c, irwrite_c, regwrite_c;
  logic       retire;
  logic       illegal_q;
  logic [CNT_W-1:0] instret_q;

  // With single-cycle memory every access completes immediately.
  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state == TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    immsrc     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALU_ADD;
    retire     = 1'b0;

    unique case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = rdy;
        pcwrite   = rdy;
        if (rdy) next_state = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here so BREX can select ALUOut.
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = RTYPEEX;
          OP_BEQ:       next_state = BREX;
          OP_BNE:       next_state = EXT_EN ? BREX : TRAP;
          OP_ADDI:      next_state = IMMEX;
          OP_SLTI, OP_ANDI, OP_ORI:
                        next_state = EXT_EN ? IMMEX : TRAP;
          OP_J:         next_state = JEX;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (rdy) next_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        // The write strobe stays up for the whole stall so the memory
        // sees a stable request until it acknowledges.
        iord       = 1'b1;
        memwrite_c = 1'b1;
        if (rdy) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BREX: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = (opcode == OP_BEQ);
        branchne   = (opcode == OP_BNE);
        retire     = 1'b1;
        next_state = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immsrc  = is_zext_op(opcode);
        case (opcode)
          OP_SLTI: aluop = ALU_SLT;
          OP_ANDI: aluop = ALU_AND;
          OP_ORI:  aluop = ALU_OR;
          default: aluop = ALU_ADD;
        endcase
        next_state = IMMWB;
      end
      IMMWB: begin
        // Keep the extender selection stable through writeback.
        immsrc     = is_zext_op(opcode);
        regwrite_c = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      TRAP: begin
        pcsrc      = 2'b11;
        pcwrite    = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  aludec_ext u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Strobes are masked by reset directly so nothing fires while it is held,
  // even though FETCH would otherwise raise irwrite/pcen on a ready memory.
  assign pcen     = reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign memwrite = reset & memwrite_c;
  assign irwrite  = reset & irwrite_c;
  assign regwrite = reset & regwrite_c;

  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state_o = state;

endmodule

// File: tb/tb_mc_controller_ext.sv
module tb_mc_controller_ext;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                         S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7, S_BREX = 4'd8,
                         S_IMMEX = 4'd9, S_IMMWB = 4'd10, S_JEX = 4'd11,
                         S_TRAP = 4'd12;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101, O_ADDI = 6'b001000,
                         O_SLTI = 6'b001010, O_ANDI = 6'b001100, O_ORI = 6'b001101,
                         O_J = 6'b000010, O_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b000111;

  localparam logic [5:0] OPS [12] = '{O_R, O_LW, O_SW, O_BEQ, O_BNE, O_ADDI,
                                      O_SLTI, O_ANDI, O_ORI, O_J, O_BAD, 6'b011011};
  localparam logic [5:0] FNS [6] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_BAD};

  localparam int K_MEM = 0, K_R = 1, K_BR = 2, K_IMM = 3, K_J = 4, K_TRAP = 5;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, immsrc;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  aluc;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn [2];
  logic [5:0] opc [2], fun [2];
  logic       zr [2], mrdy [2];
  logic       pcen_o [2], memwrite_o [2], irwrite_o [2], regwrite_o [2];
  logic       alusrca_o [2], iord_o [2], memtoreg_o [2], regdst_o [2], immsrc_o [2];
  logic [1:0] alusrcb_o [2], pcsrc_o [2];
  logic [2:0] aluc_o [2];
  logic       ill_o [2];
  logic [3:0] st_o [2];
  logic [3:0]  cnt0;
  logic [31:0] cnt1;

  // Reference model state: spec-level counters, not DUT state.
  bit          mw_m [2];
  bit          ext_m [2];
  logic [31:0] mask [2];
  logic [31:0] cnt_m [2];
  logic        ill_m [2];

  vec_t q0 [$];
  vec_t q1 [$];
  vec_t ex0, ex1;
  int n_checks = 0;
  int n_fail = 0;

  mc_controller_ext #(.MEM_WAIT(1), .EXT_ISA(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rstn[0]), .opcode(opc[0]), .funct(fun[0]), .zero(zr[0]),
    .mem_ready(mrdy[0]), .pcen(pcen_o[0]), .memwrite(memwrite_o[0]),
    .irwrite(irwrite_o[0]), .regwrite(regwrite_o[0]), .alusrca(alusrca_o[0]),
    .iord(iord_o[0]), .memtoreg(memtoreg_o[0]), .regdst(regdst_o[0]),
    .immsrc(immsrc_o[0]), .alusrcb(alusrcb_o[0]), .pcsrc(pcsrc_o[0]),
    .alucontrol(aluc_o[0]), .illegal(ill_o[0]), .instret(cnt0), .state_o(st_o[0])
  );

  mc_controller_ext #(.MEM_WAIT(0), .EXT_ISA(0), .CNT_W(32)) dut1 (
    .clk(clk), .reset(rstn[1]), .opcode(opc[1]), .funct(fun[1]), .zero(zr[1]),
    .mem_ready(mrdy[1]), .pcen(pcen_o[1]), .memwrite(memwrite_o[1]),
    .irwrite(irwrite_o[1]), .regwrite(regwrite_o[1]), .alusrca(alusrca_o[1]),
    .iord(iord_o[1]), .memtoreg(memtoreg_o[1]), .regdst(regdst_o[1]),
    .immsrc(immsrc_o[1]), .alusrcb(alusrcb_o[1]), .pcsrc(pcsrc_o[1]),
    .alucontrol(aluc_o[1]), .illegal(ill_o[1]), .instret(cnt1), .state_o(st_o[1])
  );

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic vec_t obs(input int i);
    vec_t a;
    a.st = st_o[i];        a.pcen = pcen_o[i];       a.memwrite = memwrite_o[i];
    a.irwrite = irwrite_o[i]; a.regwrite = regwrite_o[i]; a.alusrca = alusrca_o[i];
    a.iord = iord_o[i];    a.memtoreg = memtoreg_o[i]; a.regdst = regdst_o[i];
    a.immsrc = immsrc_o[i]; a.alusrcb = alusrcb_o[i]; a.pcsrc = pcsrc_o[i];
    a.aluc = aluc_o[i];    a.ill = ill_o[i];
    a.cnt = (i == 0) ? {28'd0, cnt0} : cnt1;
    return a;
  endfunction

  function automatic vec_t base(input int i, input logic [3:0] s);
    vec_t e;
    e = '0;
    e.st = s;
    e.aluc = 3'b010;
    e.ill = ill_m[i];
    e.cnt = cnt_m[i];
    return e;
  endfunction

  function automatic logic [2:0] rtab(input logic [5:0] fn);
    case (fn)
      F_ADD:   return 3'b010;
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_SLT:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int kind(input int i, input logic [5:0] op);
    case (op)
      O_LW, O_SW:              return K_MEM;
      O_R:                     return K_R;
      O_BEQ:                   return K_BR;
      O_BNE:                   return ext_m[i] ? K_BR : K_TRAP;
      O_ADDI:                  return K_IMM;
      O_SLTI, O_ANDI, O_ORI:   return ext_m[i] ? K_IMM : K_TRAP;
      O_J:                     return K_J;
      default:                 return K_TRAP;
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input vec_t a, input vec_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got st=%0d vec=%h, required st=%0d vec=%h",
               nm, i, $time, a.st, a, e.st, e);
    end
  endtask

  task automatic step(input int i, input logic rv, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input vec_t e);
    @(negedge clk);
    rstn[i] = rv; opc[i] = op; fun[i] = fn; zr[i] = z; mrdy[i] = mr;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic retire(input int i);
    cnt_m[i] = (cnt_m[i] + 32'd1) & mask[i];
  endtask

  task automatic reset_hold(input int i, input int n);
    vec_t e;
    cnt_m[i] = '0;
    ill_m[i] = 1'b0;
    e = base(i, S_FETCH);
    e.alusrcb = 2'b01;
    for (int c = 0; c < n; c++) step(i, 1'b0, r6(), r6(), rb(), 1'b1, e);
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic async_reset(input int i);
    vec_t e;
    #3;
    rstn[i] = 1'b0;
    cnt_m[i] = '0;
    ill_m[i] = 1'b0;
    #1;
    e = base(i, S_FETCH);
    e.alusrcb = 2'b01;
    chk("async_reset", i, obs(i), e);
    reset_hold(i, 2);
  endtask

  task automatic run_instr(input int i, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fst, input int mst, input int cut);
    vec_t e;
    int k;
    k = kind(i, op);
    if (mw_m[i]) begin
      for (int s = 0; s < fst; s++) begin
        e = base(i, S_FETCH); e.alusrcb = 2'b01;
        step(i, 1'b1, r6(), r6(), rb(), 1'b0, e);
      end
    end
    e = base(i, S_FETCH); e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
    step(i, 1'b1, r6(), r6(), rb(), mw_m[i] ? 1'b1 : rb(), e);
    e = base(i, S_DECODE); e.alusrcb = 2'b11;
    step(i, 1'b1, op, fn, rb(), rb(), e);
    case (k)
      K_MEM: begin
        e = base(i, S_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(i, 1'b1, op, fn, rb(), rb(), e);
        e = base(i, (op == O_LW) ? S_MEMRD : S_MEMWR);
        e.iord = 1'b1;
        e.memwrite = (op == O_SW);
        if (mw_m[i]) begin
          for (int s = 0; s < mst; s++) begin
            step(i, 1'b1, op, fn, rb(), 1'b0, e);
            if (s == cut) begin
              async_reset(i);
              return;
            end
          end
        end
        step(i, 1'b1, op, fn, rb(), mw_m[i] ? 1'b1 : rb(), e);
        if (op == O_LW) begin
          e = base(i, S_MEMWB); e.memtoreg = 1'b1; e.regwrite = 1'b1;
          step(i, 1'b1, op, fn, rb(), rb(), e);
        end
        retire(i);
      end
      K_R: begin
        e = base(i, S_RTYPEEX); e.alusrca = 1'b1; e.aluc = rtab(fn);
        step(i, 1'b1, op, fn, rb(), rb(), e);
        e = base(i, S_RTYPEWB); e.regdst = 1'b1; e.regwrite = 1'b1;
        step(i, 1'b1, op, fn, rb(), rb(), e);
        retire(i);
      end
      K_BR: begin
        e = base(i, S_BREX); e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (op == O_BEQ) ? z : ~z;
        step(i, 1'b1, op, fn, z, rb(), e);
        retire(i);
      end
      K_IMM: begin
        e = base(i, S_IMMEX); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        e.aluc = (op == O_SLTI) ? 3'b111 : (op == O_ANDI) ? 3'b000 :
                 (op == O_ORI) ? 3'b001 : 3'b010;
        e.immsrc = (op == O_ANDI) || (op == O_ORI);
        step(i, 1'b1, op, fn, rb(), rb(), e);
        e = base(i, S_IMMWB); e.regwrite = 1'b1;
        e.immsrc = (op == O_ANDI) || (op == O_ORI);
        step(i, 1'b1, op, fn, rb(), rb(), e);
        retire(i);
      end
      K_J: begin
        e = base(i, S_JEX); e.pcsrc = 2'b10; e.pcen = 1'b1;
        step(i, 1'b1, op, fn, rb(), rb(), e);
        retire(i);
      end
      default: begin
        e = base(i, S_TRAP); e.pcsrc = 2'b11; e.pcen = 1'b1;
        step(i, 1'b1, op, fn, rb(), rb(), e);
        ill_m[i] = 1'b1;
      end
    endcase
  endtask

  task automatic run_random(input int i, input int n);
    for (int r = 0; r < n; r++) begin
      run_instr(i, OPS[$urandom_range(0, 11)], FNS[$urandom_range(0, 5)], rb(),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  task automatic drive0();
    reset_hold(0, 2);
    run_instr(0, O_LW, r6(), 1'b0, 3, 2, -1);
    run_instr(0, O_R, F_ADD, 1'b0, 0, 0, -1);
    run_instr(0, O_BNE, r6(), 1'b0, 1, 0, -1);
    run_instr(0, O_BNE, r6(), 1'b1, 0, 0, -1);
    run_instr(0, O_BEQ, r6(), 1'b1, 0, 0, -1);
    run_instr(0, O_BEQ, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_ORI, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_ANDI, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_SLTI, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_ADDI, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_J, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_SW, r6(), 1'b0, 0, 2, -1);
    for (int f = 0; f < 6; f++) run_instr(0, O_R, FNS[f], rb(), 0, 0, -1);
    run_instr(0, O_BAD, r6(), 1'b0, 0, 0, -1);
    run_random(0, 40);
    for (int g = 0; g < 16 && cnt_m[0] != 32'd15; g++) run_instr(0, O_J, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_ADDI, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_BAD, r6(), 1'b0, 0, 0, -1);
    run_instr(0, O_LW, r6(), 1'b0, 1, 3, 1);
    run_instr(0, O_R, F_SUB, 1'b0, 1, 0, -1);
  endtask

  task automatic drive1();
    reset_hold(1, 2);
    run_instr(1, O_R, F_ADD, 1'b0, 2, 0, -1);
    run_instr(1, O_LW, r6(), 1'b0, 3, 2, -1);
    run_instr(1, O_SW, r6(), 1'b0, 1, 2, -1);
    run_instr(1, O_BEQ, r6(), 1'b1, 0, 0, -1);
    run_instr(1, O_ORI, r6(), 1'b0, 0, 0, -1);
    run_instr(1, O_BNE, r6(), 1'b0, 0, 0, -1);
    run_instr(1, O_ANDI, r6(), 1'b0, 0, 0, -1);
    run_instr(1, O_SLTI, r6(), 1'b0, 0, 0, -1);
    run_instr(1, O_ADDI, r6(), 1'b0, 0, 0, -1);
    run_instr(1, O_J, r6(), 1'b0, 0, 0, -1);
    run_random(1, 30);
  endtask

  // Scoreboard monitor: compares each presented cycle against the queued model output.
  always @(negedge clk) begin
    #2;
    if (q0.size() > 0) begin
      ex0 = q0.pop_front();
      chk("cycle", 0, obs(0), ex0);
    end
    if (q1.size() > 0) begin
      ex1 = q1.pop_front();
      chk("cycle", 1, obs(1), ex1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mw_m[0] = 1'b1;  ext_m[0] = 1'b1;  mask[0] = 32'h0000_000F;
    mw_m[1] = 1'b0;  ext_m[1] = 1'b0;  mask[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b1; opc[i] = '0; fun[i] = '0; zr[i] = 1'b0; mrdy[i] = 1'b0;
      cnt_m[i] = '0; ill_m[i] = 1'b0;
    end
    #1;
    rstn[0] = 1'b0;
    rstn[1] = 1'b0;
    fork
      drive0();
      drive1();
    join
    repeat (2) @(negedge clk);
    #5;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, required 0/0",
               q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
